// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a program of PROG_LEN words out of a
// synchronous ROM and hands them to decode over a valid/ready register with a one-entry skid buffer.
module fetch_unit #(
    parameter int PROG_LEN = 12
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    input  logic        br_valid,
    input  logic [5:0]  br_target,
    output logic [31:0] ir,
    output logic [5:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        halted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [5:0] PROG_END = 6'(PROG_LEN);

    logic [1:0]  state_reg,      state_next;
    logic [5:0]  pc_reg,         pc_next;
    logic        pend_reg,       pend_next;
    logic [5:0]  pend_pc_reg,    pend_pc_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_data_reg,  skid_data_next;
    logic [5:0]  skid_pc_reg,    skid_pc_next;
    logic [31:0] ir_reg,         ir_next;
    logic [5:0]  ir_pc_reg,      ir_pc_next;
    logic        ir_valid_reg,   ir_valid_next;

    logic        out_free;
    logic        issue;

    assign out_free = !ir_valid_reg || ir_ready;

    // Never issue when the data it would return has nowhere to go.
    assign issue = (state_reg == ST_RUN) && !br_valid && !skid_valid_reg
                 && !(ir_valid_reg && !ir_ready && pend_reg)
                 && (pc_reg < PROG_END);

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_next       = 1'b0;
        pend_pc_next    = pend_pc_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_pc_next    = skid_pc_reg;
        ir_next         = ir_reg;
        ir_pc_next      = ir_pc_reg;
        ir_valid_next   = ir_valid_reg;

        if (br_valid) begin
            // Redirect flushes everything in flight, including this cycle's ROM word.
            pc_next         = br_target;
            skid_valid_next = 1'b0;
            ir_valid_next   = 1'b0;
            state_next      = (br_target < PROG_END) ? ST_RUN : ST_HALT;
        end else begin
            case (state_reg)
                ST_IDLE: if (start) state_next = ST_RUN;
                ST_RUN:  if (pc_reg >= PROG_END) state_next = ST_HALT;
                default: state_next = state_reg;
            endcase

            if (issue) begin
                pc_next      = pc_reg + 6'd1;
                pend_next    = 1'b1;
                pend_pc_next = pc_reg;
            end

            if (out_free) begin
                if (skid_valid_reg) begin
                    ir_next         = skid_data_reg;
                    ir_pc_next      = skid_pc_reg;
                    ir_valid_next   = 1'b1;
                    skid_valid_next = 1'b0;
                end else if (pend_reg) begin
                    ir_next       = rom_data;
                    ir_pc_next    = pend_pc_reg;
                    ir_valid_next = 1'b1;
                end else begin
                    ir_valid_next = 1'b0;
                end
            end else if (pend_reg) begin
                skid_data_next  = rom_data;
                skid_pc_next    = pend_pc_reg;
                skid_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= 6'd0;
            pend_reg       <= 1'b0;
            pend_pc_reg    <= 6'd0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= 32'd0;
            skid_pc_reg    <= 6'd0;
            ir_reg         <= 32'd0;
            ir_pc_reg      <= 6'd0;
            ir_valid_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_reg       <= pend_next;
            pend_pc_reg    <= pend_pc_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_pc_reg    <= skid_pc_next;
            ir_reg         <= ir_next;
            ir_pc_reg      <= ir_pc_next;
            ir_valid_reg   <= ir_valid_next;
        end
    end

    assign rom_addr = pc_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign halted   = (state_reg == ST_HALT) && !pend_reg && !skid_valid_reg && !ir_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model returns 32'h1000_0000+addr one cycle
// after the address; every decode transfer is checked against the expected program order.
module tb_fetch_unit;

    logic        clka;
    logic        rst;
    logic        start;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        br_valid;
    logic [5:0]  br_target;
    logic [31:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_pc   = 0;
    int xfer_cnt = 0;

    fetch_unit #(.PROG_LEN(12)) dut (
        .clka      (clka),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .br_valid  (br_valid),
        .br_target (br_target),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .halted    (halted)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    always @(posedge clka) rom_data <= 32'h1000_0000 + {26'd0, rom_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; any transfer happening on this edge is checked against program order.
    task automatic step();
        if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
            chk("xfer_pc", {26'd0, ir_pc}, exp_pc);
            chk("xfer_ir", ir, 32'h1000_0000 + exp_pc);
            $display("xfer ir_pc=%0d ir=%08h", ir_pc, ir);
            exp_pc++;
            xfer_cnt++;
        end
        @(posedge clka);
        #1;
    endtask

    task automatic run_until_halted(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        br_valid  = 1'b1;
        br_target = 6'd5;
        ir_ready  = 1'b1;
        step();
        step();
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_rom_addr", rom_addr, 32'd0);
        chk("rst_halted", halted, 1'b0);

        rst = 1'b0; start = 1'b0; br_valid = 1'b0; br_target = 6'd0;
        repeat (3) step();
        chk("idle_ir_valid", ir_valid, 1'b0);
        chk("idle_rom_addr", rom_addr, 32'd0);

        // Plain run from start with decode always ready.
        exp_pc = 0; xfer_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_entry_addr", rom_addr, 32'd0);
        step();
        chk("lat1_ir_valid", ir_valid, 1'b0);
        chk("lat1_rom_addr", rom_addr, 32'd1);
        step();
        chk("first_ir_valid", ir_valid, 1'b1);
        chk("first_ir_pc", ir_pc, 32'd0);
        chk("first_ir", ir, 32'h1000_0000);
        run_until_halted(40);
        chk("run_xfer_cnt", xfer_cnt, 32'd12);
        chk("run_pc_stop", rom_addr, 32'd12);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_ignored_halted", halted, 1'b1);
        chk("start_ignored_valid", ir_valid, 1'b0);

        // Restart from halt via redirect to 2, with a 5-cycle decode stall mid-stream.
        exp_pc = 2; xfer_cnt = 0;
        br_valid = 1'b1; br_target = 6'd2;
        step();
        br_valid = 1'b0;
        chk("br2_addr", rom_addr, 32'd2);
        chk("br2_not_halted", halted, 1'b0);
        step();
        step();
        chk("br2_first_valid", ir_valid, 1'b1);
        chk("br2_first_pc", ir_pc, 32'd2);
        step();
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ir", ir, 32'h1000_0003);
            chk("stall_ir_pc", ir_pc, 32'd3);
            chk("stall_valid", ir_valid, 1'b1);
            chk("stall_pc_frozen", rom_addr, 32'd5);
        end
        ir_ready = 1'b1;
        run_until_halted(40);
        chk("br2_xfer_cnt", xfer_cnt, 32'd10);

        // Redirect to 3 while word 5 sits in ir and word 6 in the skid buffer.
        exp_pc = 0; xfer_cnt = 0;
        br_valid = 1'b1; br_target = 6'd0;
        step();
        br_valid = 1'b0;
        repeat (7) step();
        chk("pre_br_ir_pc", ir_pc, 32'd5);
        ir_ready = 1'b0;
        step();
        chk("pre_br_hold", ir_pc, 32'd5);
        br_valid = 1'b1; br_target = 6'd3;
        step();
        br_valid = 1'b0; ir_ready = 1'b1;
        chk("br3_xfer_before", xfer_cnt, 32'd5);
        chk("br3_flush_valid", ir_valid, 1'b0);
        chk("br3_addr", rom_addr, 32'd3);
        exp_pc = 3;
        step();
        chk("br3_bubble", ir_valid, 1'b0);
        step();
        chk("br3_valid", ir_valid, 1'b1);
        chk("br3_ir", ir, 32'h1000_0003);
        chk("br3_ir_pc", ir_pc, 32'd3);
        repeat (3) step();
        br_valid = 1'b1; br_target = 6'd12;
        step();
        br_valid = 1'b0;
        chk("br12_halted", halted, 1'b1);
        chk("br12_valid", ir_valid, 1'b0);
        chk("br12_addr", rom_addr, 32'd12);
        step();
        chk("br12_stays_halted", halted, 1'b1);

        // Reset in the middle of a stream.
        exp_pc = 0; xfer_cnt = 0;
        br_valid = 1'b1; br_target = 6'd0;
        step();
        br_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", ir_valid, 1'b0);
        chk("mrst_ir", ir, 32'd0);
        chk("mrst_ir_pc", ir_pc, 32'd0);
        chk("mrst_addr", rom_addr, 32'd0);
        chk("mrst_halted", halted, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_no_valid", ir_valid, 1'b0);
        end
        exp_pc = 0; xfer_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mrst_restart_valid", ir_valid, 1'b1);
        chk("mrst_restart_pc", ir_pc, 32'd0);
        run_until_halted(40);
        chk("mrst_xfer_cnt", xfer_cnt, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
